// File: rtl/uart_reg_bridge_if.sv
`default_nettype none
// ============================================================================
// uart_reg_bridge_if : byte-stream, response and register-bus signals of the
//                      UART register bridge.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_reg_bridge_if;
  logic       rx_data_valid;
  logic [7:0] rx_data;
  logic       rx_data_error;
  logic       tx_data_valid;
  logic [7:0] tx_data;
  logic       tx_data_ready;
  logic       reg_req;
  logic       reg_we;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_ack;
  logic [7:0] reg_rdata;
  logic       frame_err;

  modport master (
    input  rx_data_valid, rx_data, rx_data_error, tx_data_ready, reg_ack, reg_rdata,
    output tx_data_valid, tx_data, reg_req, reg_we, reg_addr, reg_wdata, frame_err
  );

  modport slave (
    output rx_data_valid, rx_data, rx_data_error, tx_data_ready, reg_ack, reg_rdata,
    input  tx_data_valid, tx_data, reg_req, reg_we, reg_addr, reg_wdata, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_reg_bridge.sv
`default_nettype none
// ============================================================================
// uart_reg_bridge : parses 'W' addr data / 'R' addr commands from the UART RX
//                   stream, runs one register access, returns one reply byte.
//                   Optional macro UART_BRIDGE_ACK_TIMEOUT_EN adds a reg_ack timeout.
// Revision: 1.0 - initial release
// ============================================================================
module uart_reg_bridge #(
  parameter int BYTE_TIMEOUT = 50000,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_reg_bridge_if.master bus
);

  localparam logic [7:0] C_OP_WRITE = 8'h57;
  localparam logic [7:0] C_OP_READ  = 8'h52;
  localparam logic [7:0] C_RSP_OK   = 8'h4B;
  localparam logic [7:0] C_RSP_UNK  = 8'h3F;
  localparam logic [7:0] C_RSP_ERR  = 8'h45;
  localparam logic [7:0] C_RSP_TO   = 8'h54;

  localparam int            CW          = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [CW-1:0] C_BYTE_LAST = CW'(BYTE_TIMEOUT - 1);
  localparam logic [CW-1:0] C_BYTE_MAX  = CW'(BYTE_TIMEOUT);

  if (BYTE_TIMEOUT < 1 || ACK_TIMEOUT < 1) begin : g_param_check
    $error("uart_reg_bridge: BYTE_TIMEOUT and ACK_TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_ADDR = 3'd1,
    S_GET_DATA = 3'd2,
    S_BUS      = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_tx_valid, w_tx_valid_nxt;
  logic [7:0]    r_tx_data, w_tx_data_nxt;
  logic          r_req, w_req_nxt;
  logic          r_we, w_we_nxt;
  logic [7:0]    r_addr, w_addr_nxt;
  logic [7:0]    r_wdata, w_wdata_nxt;
  logic          r_ferr, w_ferr_nxt;
  logic [CW-1:0] r_byte_cnt, w_byte_cnt_nxt;
  logic          w_byte_expire;
  logic          w_ack_expire;

  // A byte arriving in the expiry cycle is handled before the expiry test.
  assign w_byte_expire = (r_byte_cnt >= C_BYTE_LAST);

`ifdef UART_BRIDGE_ACK_TIMEOUT_EN
  localparam int            AW         = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW-1:0] C_ACK_LAST = AW'(ACK_TIMEOUT - 1);
  localparam logic [AW-1:0] C_ACK_MAX  = AW'(ACK_TIMEOUT);

  logic [AW-1:0] r_ack_cnt, w_ack_cnt_nxt;

  assign w_ack_expire = r_req && (r_ack_cnt >= C_ACK_LAST);

  always_comb begin
    w_ack_cnt_nxt = '0;
    if (r_state == S_BUS && r_req && !bus.reg_ack && !w_ack_expire)
      w_ack_cnt_nxt = (r_ack_cnt == C_ACK_MAX) ? r_ack_cnt : r_ack_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ack_cnt <= '0;
    else          r_ack_cnt <= w_ack_cnt_nxt;
  end
`else
  assign w_ack_expire = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_data_nxt  = r_tx_data;
    w_req_nxt      = r_req;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_ferr_nxt     = 1'b0;
    w_byte_cnt_nxt = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.rx_data_valid) begin
          if (bus.rx_data_error) begin
            w_ferr_nxt     = 1'b1;
            w_tx_data_nxt  = C_RSP_ERR;
            w_tx_valid_nxt = 1'b1;
            w_state_nxt    = S_RESP;
          end else if (bus.rx_data == C_OP_WRITE || bus.rx_data == C_OP_READ) begin
            w_we_nxt    = (bus.rx_data == C_OP_WRITE);
            w_state_nxt = S_GET_ADDR;
          end else begin
            w_tx_data_nxt  = C_RSP_UNK;
            w_tx_valid_nxt = 1'b1;
            w_state_nxt    = S_RESP;
          end
        end
      end
      S_GET_ADDR, S_GET_DATA: begin
        if (bus.rx_data_valid) begin
          if (bus.rx_data_error) begin
            w_ferr_nxt     = 1'b1;
            w_tx_data_nxt  = C_RSP_ERR;
            w_tx_valid_nxt = 1'b1;
            w_state_nxt    = S_RESP;
          end else if (r_state == S_GET_ADDR) begin
            w_addr_nxt = bus.rx_data;
            if (r_we) begin
              w_state_nxt = S_GET_DATA;
            end else begin
              w_req_nxt   = 1'b1;
              w_state_nxt = S_BUS;
            end
          end else begin
            w_wdata_nxt = bus.rx_data;
            w_req_nxt   = 1'b1;
            w_state_nxt = S_BUS;
          end
        end else if (w_byte_expire) begin
          w_ferr_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_byte_cnt_nxt = (r_byte_cnt == C_BYTE_MAX) ? r_byte_cnt : r_byte_cnt + 1'b1;
        end
      end
      S_BUS: begin
        w_ferr_nxt = bus.rx_data_valid;
        if (bus.reg_ack) begin
          w_req_nxt      = 1'b0;
          w_tx_data_nxt  = r_we ? C_RSP_OK : bus.reg_rdata;
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = S_RESP;
        end else if (w_ack_expire) begin
          w_req_nxt      = 1'b0;
          w_ferr_nxt     = 1'b1;
          w_tx_data_nxt  = C_RSP_TO;
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = S_RESP;
        end
      end
      S_RESP: begin
        w_ferr_nxt = bus.rx_data_valid;
        if (r_tx_valid && bus.tx_data_ready) begin
          w_tx_valid_nxt = 1'b0;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 8'h00;
      r_wdata    <= 8'h00;
      r_ferr     <= 1'b0;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_req      <= w_req_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_ferr     <= w_ferr_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
    end
  end

  assign bus.tx_data_valid = r_tx_valid;
  assign bus.tx_data       = r_tx_data;
  assign bus.reg_req       = r_req;
  assign bus.reg_we        = r_we;
  assign bus.reg_addr      = r_addr;
  assign bus.reg_wdata     = r_wdata;
  assign bus.frame_err     = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
`default_nettype none
// ============================================================================
// tb_uart_reg_bridge : scoreboard bench for uart_reg_bridge (tx bytes and bus
//                      accesses queued by stimulus, popped by monitors).
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_reg_bridge;
  localparam int C_BYTE_TO = 20;
  localparam int C_ACK_TO  = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_reg_bridge_if bif ();

  uart_reg_bridge #(
    .BYTE_TIMEOUT(C_BYTE_TO),
    .ACK_TIMEOUT (C_ACK_TO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bif.master)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  tx_q[$];
  logic [17:0] bus_q[$];   // {check_wdata, we, addr, wdata}
  int          n_ferr = 0;
  int          n_req = 0;
  int          ack_delay = 0;
  logic [7:0]  rdata_val = 8'h00;
  int          req_age = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register responder: ack arrives ack_delay cycles after reg_req rises (never if < 0).
  initial begin
    bif.reg_ack   = 1'b0;
    bif.reg_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (bif.reg_req) req_age++;
      else             req_age = 0;
      bif.reg_ack   = (ack_delay >= 0) && bif.reg_req && (req_age == ack_delay + 1);
      bif.reg_rdata = bif.reg_ack ? rdata_val : 8'hEE;
    end
  end

  logic        tx_held = 1'b0;
  logic [7:0]  tx_prev = 8'h00;
  logic        req_prev = 1'b0;
  logic [16:0] bus_prev = '0;
  logic [17:0] bus_exp;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bif.frame_err) n_ferr++;
      if (bif.reg_req && !req_prev) n_req++;
      if (tx_held) begin
        check("tx_hold_valid", bif.tx_data_valid, 1);
        check("tx_hold_data", bif.tx_data, tx_prev);
      end
      if (bif.tx_data_valid && bif.tx_data_ready) begin
        if (tx_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL tx_unexpected: got %02h expected no byte", bif.tx_data);
        end else begin
          check("tx_byte", bif.tx_data, tx_q.pop_front());
        end
      end
      if (req_prev && bif.reg_req)
        check("bus_stable", {bif.reg_we, bif.reg_addr, bif.reg_wdata}, bus_prev);
      if (bif.reg_req && bif.reg_ack) begin
        if (bus_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL bus_unexpected: got addr %02h expected no access", bif.reg_addr);
        end else begin
          bus_exp = bus_q.pop_front();
          check("bus_we", bif.reg_we, bus_exp[16]);
          check("bus_addr", bif.reg_addr, bus_exp[15:8]);
          if (bus_exp[17]) check("bus_wdata", bif.reg_wdata, bus_exp[7:0]);
        end
      end
      tx_held  = bif.tx_data_valid && !bif.tx_data_ready;
      tx_prev  = bif.tx_data;
      req_prev = bif.reg_req;
      bus_prev = {bif.reg_we, bif.reg_addr, bif.reg_wdata};
    end else begin
      tx_held  = 1'b0;
      req_prev = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic err = 1'b0);
    bif.rx_data       = b;
    bif.rx_data_error = err;
    bif.rx_data_valid = 1'b1;
    @(posedge clk); #1;
    bif.rx_data_valid = 1'b0;
    bif.rx_data_error = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while ((tx_q.size() != 0 || bif.tx_data_valid || bif.reg_req) && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    check({name, "_drained"}, (i < 200), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_valid(input string name);
    int i = 0;
    while (!bif.tx_data_valid && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    check({name, "_tx_seen"}, (i < 50), 1);
  endtask

  int f0, r0, cyc;

  initial begin
    bif.rx_data_valid = 1'b0;
    bif.rx_data       = 8'h00;
    bif.rx_data_error = 1'b0;
    bif.tx_data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", bif.tx_data_valid, 0);
    check("rst_tx_data", bif.tx_data, 8'h00);
    check("rst_reg_req", bif.reg_req, 0);
    check("rst_reg_we", bif.reg_we, 0);
    check("rst_reg_addr", bif.reg_addr, 8'h00);
    check("rst_reg_wdata", bif.reg_wdata, 8'h00);
    check("rst_frame_err", bif.frame_err, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Write command, ack two cycles after the request
    ack_delay = 2; r0 = n_req;
    bus_q.push_back({1'b1, 1'b1, 8'h10, 8'hA5});
    tx_q.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5);
    wait_drain("write");
    check("write_req_count", n_req - r0, 1);

    // Read command with the response held off for 5 cycles
    ack_delay = 1; rdata_val = 8'h3C; r0 = n_req;
    bif.tx_data_ready = 1'b0;
    bus_q.push_back({1'b0, 1'b0, 8'h22, 8'h00});
    tx_q.push_back(8'h3C);
    send_byte(8'h52); send_byte(8'h22);
    wait_tx_valid("read");
    repeat (5) @(posedge clk);
    #1;
    check("read_held_data", bif.tx_data, 8'h3C);
    bif.tx_data_ready = 1'b1;
    wait_drain("read");
    check("read_req_count", n_req - r0, 1);

    // Minimum latency with same-cycle ack
    ack_delay = 0; rdata_val = 8'h99;
    bus_q.push_back({1'b0, 1'b0, 8'h55, 8'h00});
    tx_q.push_back(8'h99);
    send_byte(8'h52); send_byte(8'h55);
    check("lat_req_rise", bif.reg_req, 1);
    check("lat_tx_early", bif.tx_data_valid, 0);
    @(posedge clk); #1;
    check("lat_tx_rise", bif.tx_data_valid, 1);
    check("lat_req_fall", bif.reg_req, 0);
    wait_drain("latency");

    // Unknown opcode
    r0 = n_req;
    tx_q.push_back(8'h3F);
    send_byte(8'h41);
    wait_drain("unknown");
    check("unknown_no_req", n_req - r0, 0);

    // Parity error on the address byte
    f0 = n_ferr; r0 = n_req;
    tx_q.push_back(8'h45);
    send_byte(8'h57); send_byte(8'h10, 1'b1);
    wait_drain("parity");
    check("parity_ferr", n_ferr - f0, 1);
    check("parity_no_req", n_req - r0, 0);

    // Inter-byte timeout: silence after the opcode
    f0 = n_ferr; r0 = n_req;
    send_byte(8'h52);
    repeat (19) @(posedge clk);
    #1;
    check("timeout_not_yet", bif.frame_err, 0);
    @(posedge clk); #1;
    check("timeout_pulse", bif.frame_err, 1);
    wait_drain("timeout");
    check("timeout_ferr", n_ferr - f0, 1);
    check("timeout_no_req", n_req - r0, 0);

    // Address byte at cycle 19 after the opcode is accepted
    ack_delay = 1; rdata_val = 8'h5A; f0 = n_ferr;
    bus_q.push_back({1'b0, 1'b0, 8'h30, 8'h00});
    tx_q.push_back(8'h5A);
    send_byte(8'h52);
    repeat (18) @(posedge clk);
    #1;
    send_byte(8'h30);
    wait_drain("late_byte");
    check("late_byte_no_ferr", n_ferr - f0, 0);

    // Byte dropped while the bus access is pending
    ack_delay = 4; rdata_val = 8'h81; f0 = n_ferr;
    bus_q.push_back({1'b0, 1'b0, 8'h44, 8'h00});
    tx_q.push_back(8'h81);
    send_byte(8'h52); send_byte(8'h44);
    send_byte(8'h77);
    check("drop_pulse", bif.frame_err, 1);
    wait_drain("drop");
    check("drop_ferr", n_ferr - f0, 1);

    // Reset in the middle of a bus access, then a normal read
    ack_delay = -1;
    send_byte(8'h52); send_byte(8'h66);
    check("midbus_req", bif.reg_req, 1);
    reset_n = 1'b0;
    #1;
    check("reset_req_drop", bif.reg_req, 0);
    check("reset_tx_valid", bif.tx_data_valid, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    ack_delay = 0; rdata_val = 8'h11;
    bus_q.push_back({1'b0, 1'b0, 8'h67, 8'h00});
    tx_q.push_back(8'h11);
    send_byte(8'h52); send_byte(8'h67);
    wait_drain("after_reset");

`ifdef UART_BRIDGE_ACK_TIMEOUT_EN
    // Ack never arrives: request held ACK_TIMEOUT cycles then 'T'
    ack_delay = -1; f0 = n_ferr;
    tx_q.push_back(8'h54);
    send_byte(8'h57); send_byte(8'h33); send_byte(8'h44);
    cyc = 0;
    while (bif.reg_req && cyc < 50) begin
      cyc++;
      @(posedge clk); #1;
    end
    check("acktimeout_req_cycles", cyc, C_ACK_TO);
    check("acktimeout_pulse", bif.frame_err, 1);
    wait_drain("acktimeout");
    check("acktimeout_ferr", n_ferr - f0, 1);
`endif

    check("tx_queue_empty", tx_q.size(), 0);
    check("bus_queue_empty", bus_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion within 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
